// File: rtl/fpu_div_pkg.sv
// Shared definitions for the divide pipe: sequencer state encoding and iteration counts.
package fpu_div_pkg;

   localparam int CNT_W    = 6;
   localparam int ITER_DBL = 55;
   localparam int ITER_SNG = 26;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NORM = 3'd1,
      SHL  = 3'd2,
      LOAD = 3'd3,
      ITER = 3'd4,
      SPCL = 3'd5,
      RND  = 3'd6,
      DONE = 3'd7
   } div_state_e;

endpackage

// File: rtl/fpu_div_iter_cnt.sv
// Loadable down-counter for the subtract iterations; saturates at 1 so the last flag is stable.
module fpu_div_iter_cnt import fpu_div_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg > CNT_W'(1))) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/fpu_div_iter_ctl.sv
// Divide fraction-datapath sequencer: steps normalize, shift, iterate and round phases
// and hands the result to the output stage with a done/dest_rdy handshake.
module fpu_div_iter_ctl #(
   parameter int ITER_DBL = fpu_div_pkg::ITER_DBL,
   parameter int ITER_SNG = fpu_div_pkg::ITER_SNG
) (
   input  logic rclk,
   input  logic rst,
   input  logic div_start,
   input  logic div_dblop,
   input  logic div_special,
   input  logic div_frac_add_54,
   input  logic div_frac_out_53,
   input  logic div_dest_rdy,
   output logic div_busy,
   output logic div_done,
   output logic d1stg_step,
   output logic d3stg_fdiv,
   output logic d4stg_fdiv,
   output logic d5stg_fdivb,
   output logic d6stg_fdiv,
   output logic d6stg_fdivd,
   output logic d6stg_fdivs,
   output logic div_frac_add_in1_add,
   output logic div_frac_add_in1_load,
   output logic div_frac_add_in2_load,
   output logic div_frac_out_add_in1,
   output logic div_frac_out_add,
   output logic div_frac_out_shl1_dbl,
   output logic div_frac_out_shl1_sng,
   output logic div_frac_out_load,
   output logic d6stg_frac_out_shl1,
   output logic d6stg_frac_out_nosh
);
   import fpu_div_pkg::*;

   div_state_e       state_reg;
   logic             dbl_reg;
   logic             special_reg;
   logic             rnd_done_reg;
   logic             accept;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt_load_val;

   // The quotient bit (!div_frac_add_54) is consumed by the datapath directly.
   logic unused_add_54;
   assign unused_add_54 = div_frac_add_54;

   assign accept = div_start && !rst &&
                   ((state_reg == IDLE) || ((state_reg == DONE) && div_dest_rdy));
   assign cnt_load_val = dbl_reg ? CNT_W'(ITER_DBL) : CNT_W'(ITER_SNG);

   fpu_div_iter_cnt u_cnt (
      .clk      (rclk),
      .rst      (rst),
      .load     (state_reg == LOAD),
      .load_val (cnt_load_val),
      .dec      (state_reg == ITER),
      .last     (cnt_last)
   );

   always_ff @(posedge rclk) begin
      if (rst) begin
         state_reg    <= IDLE;
         dbl_reg      <= 1'b0;
         special_reg  <= 1'b0;
         rnd_done_reg <= 1'b0;
      end else begin
         rnd_done_reg <= 1'b0;
         if (accept) begin
            dbl_reg     <= div_dblop;
            special_reg <= div_special;
         end
         unique case (state_reg)
            IDLE: if (accept) state_reg <= NORM;
            NORM: state_reg <= SHL;
            SHL:  state_reg <= LOAD;
            LOAD: state_reg <= special_reg ? SPCL : ITER;
            ITER: if (cnt_last) state_reg <= RND;
            SPCL: state_reg <= DONE;
            RND: begin
               state_reg    <= DONE;
               rnd_done_reg <= 1'b1;
            end
            DONE: if (div_dest_rdy) state_reg <= accept ? NORM : IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      div_busy              = (state_reg != IDLE);
      div_done              = 1'b0;
      d1stg_step            = accept;
      d3stg_fdiv            = 1'b0;
      d4stg_fdiv            = 1'b0;
      d5stg_fdivb           = 1'b0;
      d6stg_fdiv            = 1'b0;
      d6stg_fdivd           = 1'b0;
      d6stg_fdivs           = 1'b0;
      div_frac_add_in1_add  = 1'b0;
      div_frac_add_in1_load = 1'b0;
      div_frac_add_in2_load = 1'b0;
      div_frac_out_add_in1  = 1'b0;
      div_frac_out_add      = 1'b0;
      div_frac_out_shl1_dbl = 1'b0;
      div_frac_out_shl1_sng = 1'b0;
      div_frac_out_load     = 1'b0;
      d6stg_frac_out_shl1   = 1'b0;
      d6stg_frac_out_nosh   = 1'b0;
      unique case (state_reg)
         SHL: d3stg_fdiv = 1'b1;
         LOAD: begin
            d4stg_fdiv            = 1'b1;
            div_frac_add_in1_load = 1'b1;
            div_frac_add_in2_load = 1'b1;
            div_frac_out_load     = 1'b1;
         end
         ITER: begin
            d5stg_fdivb           = 1'b1;
            div_frac_add_in1_add  = 1'b1;
            div_frac_add_in1_load = 1'b1;
            div_frac_out_load     = 1'b1;
            div_frac_out_shl1_dbl = dbl_reg;
            div_frac_out_shl1_sng = !dbl_reg;
         end
         SPCL: begin
            div_frac_out_add_in1 = 1'b1;
            div_frac_out_load    = 1'b1;
         end
         RND: begin
            d6stg_fdiv            = 1'b1;
            d6stg_fdivd           = dbl_reg;
            d6stg_fdivs           = !dbl_reg;
            div_frac_add_in1_load = 1'b1;
            div_frac_add_in2_load = 1'b1;
            d6stg_frac_out_nosh   = div_frac_out_53;
            d6stg_frac_out_shl1   = !div_frac_out_53;
         end
         DONE: begin
            // Rounded fraction is captured once; later stall cycles just hold it.
            div_done          = 1'b1;
            div_frac_out_add  = rnd_done_reg;
            div_frac_out_load = rnd_done_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpu_div_iter_ctl.sv
// Directed bench for fpu_div_iter_ctl: records every output per cycle, then checks phase timing.
module tb_fpu_div_iter_ctl;

   logic rclk, rst, div_start, div_dblop, div_special;
   logic div_frac_add_54, div_frac_out_53, div_dest_rdy;
   logic div_busy, div_done, d1stg_step, d3stg_fdiv, d4stg_fdiv, d5stg_fdivb;
   logic d6stg_fdiv, d6stg_fdivd, d6stg_fdivs;
   logic div_frac_add_in1_add, div_frac_add_in1_load, div_frac_add_in2_load;
   logic div_frac_out_add_in1, div_frac_out_add, div_frac_out_shl1_dbl;
   logic div_frac_out_shl1_sng, div_frac_out_load;
   logic d6stg_frac_out_shl1, d6stg_frac_out_nosh;

   localparam int B_NOSH = 0,  B_SHL1 = 1,  B_FOLD = 2,  B_SHLS = 3,  B_SHLD = 4;
   localparam int B_FOADD = 5, B_FOAI = 6,  B_A2LD = 7,  B_A1LD = 8,  B_A1ADD = 9;
   localparam int B_D6S = 10,  B_D6D = 11,  B_D6 = 12,   B_D5 = 13,   B_D4 = 14;
   localparam int B_D3 = 15,   B_D1 = 16,   B_DONE = 17, B_BUSY = 18;

   localparam logic [18:0] M_BUSY      = 19'h40000;
   localparam logic [18:0] M_BUSY_DONE = 19'h60000;
   localparam logic [18:0] M_SHL       = 19'h48000;
   localparam logic [18:0] M_LOAD      = 19'h44184;

   logic [18:0] all_out;
   assign all_out = {div_busy, div_done, d1stg_step, d3stg_fdiv, d4stg_fdiv, d5stg_fdivb,
                     d6stg_fdiv, d6stg_fdivd, d6stg_fdivs, div_frac_add_in1_add,
                     div_frac_add_in1_load, div_frac_add_in2_load, div_frac_out_add_in1,
                     div_frac_out_add, div_frac_out_shl1_dbl, div_frac_out_shl1_sng,
                     div_frac_out_load, d6stg_frac_out_shl1, d6stg_frac_out_nosh};

   logic [18:0] trace [0:127];
   int n_checks = 0;
   int n_fail   = 0;

   fpu_div_iter_ctl dut (
      .rclk(rclk), .rst(rst), .div_start(div_start), .div_dblop(div_dblop),
      .div_special(div_special), .div_frac_add_54(div_frac_add_54),
      .div_frac_out_53(div_frac_out_53), .div_dest_rdy(div_dest_rdy),
      .div_busy(div_busy), .div_done(div_done), .d1stg_step(d1stg_step),
      .d3stg_fdiv(d3stg_fdiv), .d4stg_fdiv(d4stg_fdiv), .d5stg_fdivb(d5stg_fdivb),
      .d6stg_fdiv(d6stg_fdiv), .d6stg_fdivd(d6stg_fdivd), .d6stg_fdivs(d6stg_fdivs),
      .div_frac_add_in1_add(div_frac_add_in1_add),
      .div_frac_add_in1_load(div_frac_add_in1_load),
      .div_frac_add_in2_load(div_frac_add_in2_load),
      .div_frac_out_add_in1(div_frac_out_add_in1), .div_frac_out_add(div_frac_out_add),
      .div_frac_out_shl1_dbl(div_frac_out_shl1_dbl),
      .div_frac_out_shl1_sng(div_frac_out_shl1_sng),
      .div_frac_out_load(div_frac_out_load),
      .d6stg_frac_out_shl1(d6stg_frac_out_shl1), .d6stg_frac_out_nosh(d6stg_frac_out_nosh)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Cycle 0 starts the op; inputs change 1 time unit after each rising edge, outputs
   // are captured 4 units after it.
   task automatic run_op(input logic dbl, input logic spcl, input logic f53,
                         input int rdy_cyc, input int stray_cyc, input int rst_cyc,
                         input int start2_cyc, input logic start2_dbl, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge rclk);
         #1;
         div_start       = (c == 0) || (c == stray_cyc) || (c == start2_cyc);
         div_dblop       = (c == 0) ? dbl : (c == stray_cyc) ? 1'b1 :
                           (c == start2_cyc) ? start2_dbl : 1'b0;
         div_special     = (c == 0) ? spcl : 1'b0;
         rst             = (c == rst_cyc);
         div_dest_rdy    = (c >= rdy_cyc);
         div_frac_out_53 = f53;
         div_frac_add_54 = c[0];
         #3;
         trace[c] = all_out;
      end
      div_start = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic iter_stats(input int lo, input int hi, input logic exp_dbl,
                             output int n, output int first, output int last, output int bad);
      n = 0; first = -1; last = -1; bad = 0;
      for (int c = lo; c <= hi; c++) begin
         if (trace[c][B_D5]) begin
            n++;
            if (first < 0) first = c;
            last = c;
            if (trace[c][B_SHLD] !== exp_dbl || trace[c][B_SHLS] !== !exp_dbl) bad++;
         end
      end
   endtask

   function automatic int excl_viol(input int lo, input int hi);
      int v = 0;
      for (int c = lo; c <= hi; c++) begin
         if (int'(trace[c][B_FOAI]) + int'(trace[c][B_FOADD]) + int'(trace[c][B_SHLD]) +
             int'(trace[c][B_SHLS]) > 1) v++;
         if (trace[c][B_SHL1] && trace[c][B_NOSH]) v++;
      end
      return v;
   endfunction

   task automatic test_reset();
      @(posedge rclk); #1;
      rst = 1'b1; div_start = 1'b1; div_dblop = 1'b1;
      @(posedge rclk); #1;
      rst = 1'b0; div_start = 1'b0; div_dblop = 1'b0;
      #3;
      n_checks++;
      if (all_out !== 19'h0) begin
         n_fail++; $display("FAIL reset_outputs got %h want 00000", all_out);
      end
      @(posedge rclk); #4;
      n_checks++;
      if (all_out !== 19'h0) begin
         n_fail++; $display("FAIL reset_start_dropped got %h want 00000", all_out);
      end
      $display("test_reset done");
   endtask

   task automatic test_double();
      int n, first, last, bad;
      run_op(1'b1, 1'b0, 1'b0, 0, -1, -1, -1, 1'b0, 64);
      iter_stats(0, 63, 1'b1, n, first, last, bad);
      n_checks++; if (trace[0][B_D1] !== 1'b1 || trace[0][B_BUSY] !== 1'b0) begin
         n_fail++; $display("FAIL dbl_accept got %h want step=1 busy=0", trace[0]); end
      n_checks++; if (trace[1] !== M_BUSY) begin
         n_fail++; $display("FAIL dbl_norm got %h want %h", trace[1], M_BUSY); end
      n_checks++; if (trace[2] !== M_SHL) begin
         n_fail++; $display("FAIL dbl_shl got %h want %h", trace[2], M_SHL); end
      n_checks++; if (trace[3] !== M_LOAD) begin
         n_fail++; $display("FAIL dbl_load got %h want %h", trace[3], M_LOAD); end
      n_checks++; if (n !== 55 || first !== 4 || last !== 58 || bad !== 0) begin
         n_fail++; $display("FAIL dbl_iter got n=%0d first=%0d last=%0d bad=%0d want 55 4 58 0",
                            n, first, last, bad); end
      n_checks++; if (trace[59][B_D6] !== 1'b1 || trace[59][B_D6D] !== 1'b1 ||
                      trace[59][B_D6S] !== 1'b0 || trace[59][B_SHL1] !== 1'b1 ||
                      trace[59][B_NOSH] !== 1'b0 || trace[59][B_DONE] !== 1'b0) begin
         n_fail++; $display("FAIL dbl_rnd got %h want d6,d6d,shl1 only", trace[59]); end
      n_checks++; if (trace[60][B_DONE] !== 1'b1 || trace[60][B_FOADD] !== 1'b1 ||
                      trace[60][B_FOLD] !== 1'b1) begin
         n_fail++; $display("FAIL dbl_done got %h want done,add,load", trace[60]); end
      n_checks++; if (trace[61] !== 19'h0) begin
         n_fail++; $display("FAIL dbl_idle got %h want 00000", trace[61]); end
      n_checks++; if (excl_viol(0, 63) !== 0) begin
         n_fail++; $display("FAIL dbl_onehot got %0d violations want 0", excl_viol(0, 63)); end
      $display("test_double done: iter=%0d first=%0d last=%0d", n, first, last);
   endtask

   task automatic test_single();
      int n, first, last, bad;
      run_op(1'b0, 1'b0, 1'b1, 0, -1, -1, -1, 1'b0, 36);
      iter_stats(0, 35, 1'b0, n, first, last, bad);
      n_checks++; if (n !== 26 || first !== 4 || last !== 29 || bad !== 0) begin
         n_fail++; $display("FAIL sng_iter got n=%0d first=%0d last=%0d bad=%0d want 26 4 29 0",
                            n, first, last, bad); end
      n_checks++; if (trace[30][B_D6S] !== 1'b1 || trace[30][B_D6D] !== 1'b0 ||
                      trace[30][B_NOSH] !== 1'b1 || trace[30][B_SHL1] !== 1'b0) begin
         n_fail++; $display("FAIL sng_rnd got %h want d6s,nosh", trace[30]); end
      n_checks++; if (trace[30][B_DONE] !== 1'b0 || trace[31][B_DONE] !== 1'b1) begin
         n_fail++; $display("FAIL sng_done_time got c30=%b c31=%b want 0 1",
                            trace[30][B_DONE], trace[31][B_DONE]); end
      n_checks++; if (trace[32][B_BUSY] !== 1'b0) begin
         n_fail++; $display("FAIL sng_idle got busy=%b want 0", trace[32][B_BUSY]); end
      n_checks++; if (excl_viol(0, 35) !== 0) begin
         n_fail++; $display("FAIL sng_onehot got %0d violations want 0", excl_viol(0, 35)); end
      $display("test_single done: iter=%0d", n);
   endtask

   task automatic test_special();
      int n, first, last, bad;
      run_op(1'b1, 1'b1, 1'b0, 0, -1, -1, -1, 1'b0, 10);
      iter_stats(0, 9, 1'b1, n, first, last, bad);
      n_checks++; if (n !== 0) begin
         n_fail++; $display("FAIL spcl_no_iter got %0d want 0", n); end
      n_checks++; if (trace[4][B_FOAI] !== 1'b1 || trace[4][B_FOLD] !== 1'b1 ||
                      trace[4][B_DONE] !== 1'b0) begin
         n_fail++; $display("FAIL spcl_add_in1 got %h want add_in1,load", trace[4]); end
      n_checks++; if (trace[5] !== M_BUSY_DONE) begin
         n_fail++; $display("FAIL spcl_done got %h want %h", trace[5], M_BUSY_DONE); end
      n_checks++; if (trace[6] !== 19'h0) begin
         n_fail++; $display("FAIL spcl_idle got %h want 00000", trace[6]); end
      $display("test_special done");
   endtask

   task automatic test_stall_back_to_back();
      int n, first, last, bad, dn, ld;
      run_op(1'b0, 1'b0, 1'b1, 41, 35, -1, 41, 1'b0, 80);
      dn = 0; ld = 0;
      for (int c = 31; c <= 41; c++) begin
         if (trace[c][B_DONE]) dn++;
         if (trace[c][B_DONE] && trace[c][B_FOLD]) ld++;
      end
      n_checks++; if (dn !== 11) begin
         n_fail++; $display("FAIL stall_done_held got %0d cycles want 11", dn); end
      n_checks++; if (ld !== 1 || trace[31][B_FOLD] !== 1'b1) begin
         n_fail++; $display("FAIL stall_load_once got %0d loads c31=%b want 1 1",
                            ld, trace[31][B_FOLD]); end
      n_checks++; if (trace[35] !== M_BUSY_DONE || trace[36] !== M_BUSY_DONE) begin
         n_fail++; $display("FAIL stall_start_ignored got %h %h want %h",
                            trace[35], trace[36], M_BUSY_DONE); end
      n_checks++; if (trace[41][B_D1] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_step got %b want 1", trace[41][B_D1]); end
      n_checks++; if (trace[42] !== M_BUSY) begin
         n_fail++; $display("FAIL b2b_norm got %h want %h", trace[42], M_BUSY); end
      iter_stats(42, 79, 1'b0, n, first, last, bad);
      n_checks++; if (n !== 26 || first !== 45 || bad !== 0) begin
         n_fail++; $display("FAIL b2b_iter got n=%0d first=%0d bad=%0d want 26 45 0",
                            n, first, bad); end
      n_checks++; if (trace[71][B_DONE] !== 1'b0 || trace[72][B_DONE] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_done_time got c71=%b c72=%b want 0 1",
                            trace[71][B_DONE], trace[72][B_DONE]); end
      $display("test_stall_back_to_back done: done_cycles=%0d", dn);
   endtask

   task automatic test_reset_mid_iter();
      run_op(1'b1, 1'b0, 1'b0, 0, -1, 20, 22, 1'b0, 58);
      n_checks++; if (trace[20][B_D5] !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_was_iter got %b want 1", trace[20][B_D5]); end
      n_checks++; if (trace[21] !== 19'h0) begin
         n_fail++; $display("FAIL rst_mid_outputs got %h want 00000", trace[21]); end
      n_checks++; if (trace[22][B_D1] !== 1'b1 || trace[23] !== M_BUSY) begin
         n_fail++; $display("FAIL rst_restart got step=%b c23=%h want 1 %h",
                            trace[22][B_D1], trace[23], M_BUSY); end
      n_checks++; if (trace[52][B_DONE] !== 1'b0 || trace[53][B_DONE] !== 1'b1) begin
         n_fail++; $display("FAIL rst_restart_done got c52=%b c53=%b want 0 1",
                            trace[52][B_DONE], trace[53][B_DONE]); end
      n_checks++; if (trace[54][B_BUSY] !== 1'b0) begin
         n_fail++; $display("FAIL rst_restart_idle got busy=%b want 0", trace[54][B_BUSY]); end
      $display("test_reset_mid_iter done");
   endtask

   initial begin
      rst = 1'b1; div_start = 1'b0; div_dblop = 1'b0; div_special = 1'b0;
      div_frac_add_54 = 1'b0; div_frac_out_53 = 1'b0; div_dest_rdy = 1'b0;
      repeat (3) @(posedge rclk);
      #1 rst = 1'b0;
      test_reset();
      test_double();
      test_single();
      test_special();
      test_stall_back_to_back();
      test_reset_mid_iter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
